addr_gen_queue: RTL and testbench
=================================

# addr_gen_queue

Parametrised address-generation unit with an output queue: it accepts load/store requests carrying a base, an offset, an opcode, a ROB tag and store data, and computes the effective address modulo 2^XLEN. It flags misaligned accesses and buffers results in a DEPTH-entry FIFO toward the load/store buffer. Valid/ready handshakes on both sides replace the earlier global-pause scheme, and a flush input discards all in-flight entries. It sits between dispatch/reservation stations and the load/store buffer.

## Interface
- XLEN, 32, width of base, offset, address and store data
- OP_W, 5, opcode width; all-ones (5'b11111 at default) is the "no operation" code
- ROB_W, 3, ROB tag width
- DEPTH, 4, FIFO entries; power of two, ≥2

- clk  input  1  single clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous; empties the FIFO
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request this cycle
- in_base  input  XLEN  base operand
- in_offset  input  XLEN  offset operand (sign-extended by producer)
- in_op  input  OP_W  opcode; [1:0] size (00 byte, 01 half, 10 word, 11 reserved), [2] unsigned, [3] store
- in_rob  input  ROB_W  ROB tag
- in_data  input  XLEN  store data (passed through)
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head this cycle
- out_addr  output  XLEN  effective address
- out_op  output  OP_W  opcode
- out_rob  output  ROB_W  ROB tag
- out_data  output  XLEN  store data
- out_misalign  output  1  address not aligned to access size

## Operation
- Accept: in_valid && in_ready && !flush. Write {base+offset, op, rob, data, misalign} into the tail slot and advance the wr pointer.
- Address: (in_base + in_offset) mod 2^XLEN; carry out discarded, no overflow flag.
- Misalign is computed on the sum. Half: addr[0]≠0. Word: addr[1:0]≠0. Byte: never. Size 11: always 1.
- Pop: out_valid && out_ready && !flush. Advance the rd pointer.
- count: width clog2(DEPTH+1). Push only: +1. Pop only: −1. Both: unchanged. Pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH), purely from registered count. There is no same-cycle pass-through when full.
- out_valid = (count ≠ 0). Output fields are driven from the head entry. When out_valid=0, outputs read addr 0, op all-ones, rob 0, data 0, misalign 0.
- Flush has priority over push and pop. The next cycle has count=0 and pointers=0, and a request offered in the flush cycle is dropped.
- Reset (async, any time, including mid-transfer): count, pointers and all entries clear. Every entry's op field is set to all-ones and the other fields to 0. in_ready=1 and out_valid=0 immediately, held until the first posedge after rst deasserts.

## Timing
- Latency: request accepted at edge N appears on the outputs after edge N (out_valid=1 during cycle N+1) if the FIFO was empty.
- Throughput: one accept and one pop per cycle.
- Order: strict FIFO. Entries are never reordered or merged.
- Outputs are held stable while out_valid && !out_ready.
- Full with simultaneous pop: in_ready stays 0 that cycle. The slot frees on the next cycle.
- Empty with in_valid: push only, no bypass.

## Test plan
- Reset: assert rst asynchronously mid-cycle with 2 entries queued. Required: out_valid=0, in_ready=1, out_op=5'b11111, out_rob=0 immediately. After release, the first accept emerges alone.
- Basic: base=0x1000, offset=0xFFFFFFFC, op=5'b00010, rob=5 at edge N. Required in cycle N+1: out_addr=0x00000FFC, out_misalign=0, out_rob=5.
- Wrap/misalign: base=0xFFFFFFFF, offset=2, word op. Required: out_addr=0x00000001, out_misalign=1. The same sum with a byte op gives misalign=0. A half op with addr 0x1002 gives misalign=0.
- Backpressure: out_ready=0 while pushing tags 1..5. Required: in_ready drops after 4 accepts and tag 5 waits. Raise out_ready: tags emerge 1,2,3,4 then 5, one per cycle, and in_ready returns the cycle after the first pop.
- Simultaneous push/pop at count=2 for 10 cycles. Required: count stays 2, order preserved, no drops.
- Flush: count=3 plus in_valid asserted in the flush cycle. Required next cycle: out_valid=0, in_ready=1, and the offered request never appears.

Source files
------------

// File: rtl/addr_gen_queue_if.sv
// Request/response bundle for addr_gen_queue.
//   in_*  : request channel from dispatch (valid/ready), base/offset/op/rob/data
//   out_* : result channel to the load/store buffer (valid/ready), addr/op/rob/data/misalign
// Modports: master = producer/consumer side (bench or neighbours), slave = the unit itself.
interface addr_gen_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OP_W  = 5,
  parameter int unsigned ROB_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_base;
  logic [XLEN-1:0]  in_offset;
  logic [OP_W-1:0]  in_op;
  logic [ROB_W-1:0] in_rob;
  logic [XLEN-1:0]  in_data;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_addr;
  logic [OP_W-1:0]  out_op;
  logic [ROB_W-1:0] out_rob;
  logic [XLEN-1:0]  out_data;
  logic             out_misalign;

  modport master (
    output in_valid, in_base, in_offset, in_op, in_rob, in_data, out_ready,
    input  in_ready, out_valid, out_addr, out_op, out_rob, out_data, out_misalign
  );

  modport slave (
    input  in_valid, in_base, in_offset, in_op, in_rob, in_data, out_ready,
    output in_ready, out_valid, out_addr, out_op, out_rob, out_data, out_misalign
  );
endinterface

// File: rtl/addr_gen_queue.sv
// Address-generation unit with a DEPTH-entry result FIFO.
// Computes (base + offset) mod 2^XLEN, flags misaligned accesses by size and queues
// {addr, op, rob, data, misalign} toward the load/store buffer.
// Ports:
//   clk   : clock, all state on posedge
//   rst   : asynchronous active-high reset
//   flush : synchronous, empties the FIFO (priority over push/pop)
//   bus   : addr_gen_queue_if.slave, request (in_*) and result (out_*) channels
module addr_gen_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OP_W  = 5,
  parameter int unsigned ROB_W = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  addr_gen_queue_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [OP_W-1:0] OpNop = '1;

  logic [XLEN-1:0]  r_addr [DEPTH];
  logic [OP_W-1:0]  r_op   [DEPTH];
  logic [ROB_W-1:0] r_rob  [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];
  logic             r_mis  [DEPTH];

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_nxt;

  logic            w_push;
  logic            w_pop;
  logic            w_in_ready;
  logic            w_out_valid;
  logic [XLEN-1:0] w_sum;
  logic            w_misalign;

  assign w_sum = bus.in_base + bus.in_offset;

  // Alignment is judged on the wrapped sum; reserved size always flags.
  always_comb begin
    w_misalign = 1'b0;
    unique case (bus.in_op[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_sum[0];
      2'b10:   w_misalign = |w_sum[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  // Both flags come from the registered count only: no pass-through when full.
  assign w_in_ready  = (r_count < CntW'(DEPTH));
  assign w_out_valid = (r_count != '0);

  assign w_push = bus.in_valid && w_in_ready && !flush;
  assign w_pop  = w_out_valid && bus.out_ready && !flush;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CntW'(1);
      2'b01:   w_count_nxt = r_count - CntW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Entry storage; flush leaves stale contents, they are unreachable once count is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_op[i]   <= OpNop;
        r_rob[i]  <= '0;
        r_data[i] <= '0;
        r_mis[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_addr[r_wr_ptr] <= w_sum;
      r_op[r_wr_ptr]   <= bus.in_op;
      r_rob[r_wr_ptr]  <= bus.in_rob;
      r_data[r_wr_ptr] <= bus.in_data;
      r_mis[r_wr_ptr]  <= w_misalign;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_addr     = w_out_valid ? r_addr[r_rd_ptr] : '0;
  assign bus.out_op       = w_out_valid ? r_op[r_rd_ptr]   : OpNop;
  assign bus.out_rob      = w_out_valid ? r_rob[r_rd_ptr]  : '0;
  assign bus.out_data     = w_out_valid ? r_data[r_rd_ptr] : '0;
  assign bus.out_misalign = w_out_valid ? r_mis[r_rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_addr_gen_queue.sv
// Self-checking bench for addr_gen_queue: scoreboard queue of expected results,
// one task per scenario. Inputs are driven and outputs sampled at the negedge.
module tb_addr_gen_queue;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  op;
    logic [2:0]  rob;
    logic [31:0] data;
    logic        mis;
  } ent_t;

  localparam ent_t Idle = '{addr: 32'h0, op: 5'h1f, rob: 3'h0, data: 32'h0, mis: 1'b0};

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_errors;
  ent_t sb[$];

  addr_gen_queue_if #(.XLEN(32), .OP_W(5), .ROB_W(3)) bus ();

  addr_gen_queue #(.XLEN(32), .OP_W(5), .ROB_W(3), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  function automatic ent_t model(input logic [31:0] b, input logic [31:0] o,
                                 input logic [4:0] op, input logic [2:0] rob,
                                 input logic [31:0] d);
    ent_t e;
    e.addr = b + o;
    e.op   = op;
    e.rob  = rob;
    e.data = d;
    case (op[1:0])
      2'b00:   e.mis = 1'b0;
      2'b01:   e.mis = e.addr[0];
      2'b10:   e.mis = (e.addr[1:0] != 2'b00);
      default: e.mis = 1'b1;
    endcase
    return e;
  endfunction

  function automatic ent_t obs();
    ent_t e;
    e.addr = bus.out_addr;
    e.op   = bus.out_op;
    e.rob  = bus.out_rob;
    e.data = bus.out_data;
    e.mis  = bus.out_misalign;
    return e;
  endfunction

  function automatic ent_t head_exp();
    return (sb.size() != 0) ? sb[0] : Idle;
  endfunction

  task automatic drive_req(input logic [31:0] b, input logic [31:0] o, input logic [4:0] op,
                           input logic [2:0] rob, input logic [31:0] d);
    bus.in_valid  = 1'b1;
    bus.in_base   = b;
    bus.in_offset = o;
    bus.in_op     = op;
    bus.in_rob    = rob;
    bus.in_data   = d;
  endtask

  // Updates the scoreboard from the handshakes visible now, then moves to the next negedge.
  task automatic advance();
    if (!rst) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.out_valid && bus.out_ready && sb.size() != 0) void'(sb.pop_front());
        if (bus.in_valid && bus.in_ready)
          sb.push_back(model(bus.in_base, bus.in_offset, bus.in_op, bus.in_rob, bus.in_data));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    ent_t e;
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, obs()} !== {1'b0, 1'b1, Idle}) begin
      n_errors++;
      $display("FAIL reset_init: got v=%0b r=%0b %h required v=0 r=1 %h",
               bus.out_valid, bus.in_ready, obs(), Idle);
    end
    drive_req(32'h100, 32'h4, 5'b00010, 3'd1, 32'h11);
    advance();
    drive_req(32'h200, 32'h8, 5'b00010, 3'd2, 32'h22);
    advance();
    bus.in_valid = 1'b0;
    e = head_exp();
    n_checks++;
    if ({bus.out_valid, bus.in_ready, obs()} !== {sb.size() != 0, sb.size() < 4, e}) begin
      n_errors++;
      $display("FAIL reset_prefill: got v=%0b %h required v=1 %h", bus.out_valid, obs(), e);
    end
    // Asynchronous reset mid-cycle, well away from the clock edge.
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_op, bus.out_rob, bus.out_addr} !==
        {1'b0, 1'b1, 5'h1f, 3'h0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_async: got v=%0b r=%0b op=%h rob=%0d addr=%h required v=0 r=1 op=1f rob=0 addr=0",
               bus.out_valid, bus.in_ready, bus.out_op, bus.out_rob, bus.out_addr);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drive_req(32'h600, 32'h0, 5'b00000, 3'd6, 32'h66);
    advance();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    e = head_exp();
    n_checks++;
    if ({bus.out_valid, obs()} !== {1'b1, e} || bus.out_rob !== 3'd6) begin
      n_errors++;
      $display("FAIL reset_first: got v=%0b %h required v=1 %h", bus.out_valid, obs(), e);
    end
    advance();
    n_checks++;
    if ({bus.out_valid, obs()} !== {1'b0, Idle}) begin
      n_errors++;
      $display("FAIL reset_alone: got v=%0b %h required v=0 %h", bus.out_valid, obs(), Idle);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_basic();
    ent_t e;
    bus.out_ready = 1'b0;
    drive_req(32'h1000, 32'hFFFF_FFFC, 5'b00010, 3'd5, 32'hCAFE_F00D);
    advance();
    bus.in_valid = 1'b0;
    e = head_exp();
    n_checks++;
    if ({bus.out_valid, bus.out_addr, bus.out_misalign, bus.out_rob} !==
        {1'b1, 32'h0000_0FFC, 1'b0, 3'd5}) begin
      n_errors++;
      $display("FAIL basic_const: got v=%0b addr=%h mis=%0b rob=%0d required v=1 addr=00000ffc mis=0 rob=5",
               bus.out_valid, bus.out_addr, bus.out_misalign, bus.out_rob);
    end
    n_checks++;
    if (obs() !== e) begin
      n_errors++;
      $display("FAIL basic_sb: got %h required %h", obs(), e);
    end
    // Head must hold while the consumer stalls.
    advance();
    n_checks++;
    if ({bus.out_valid, obs()} !== {1'b1, e}) begin
      n_errors++;
      $display("FAIL basic_hold: got v=%0b %h required v=1 %h", bus.out_valid, obs(), e);
    end
    bus.out_ready = 1'b1;
    advance();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap_misalign();
    logic [31:0] tb_base [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1000, 32'h0000_1000,
                                 32'h0000_1000};
    logic [31:0] tb_off  [5] = '{32'h2, 32'h2, 32'h2, 32'h1, 32'h0};
    logic [4:0]  tb_op   [5] = '{5'b00010, 5'b00000, 5'b00001, 5'b01001, 5'b00011};
    logic [31:0] tb_addr [5] = '{32'h1, 32'h1, 32'h1002, 32'h1001, 32'h1000};
    logic        tb_mis  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ent_t e;
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = 1'b1;
      drive_req(tb_base[i], tb_off[i], tb_op[i], 3'(i), 32'hA0 + 32'(i));
      advance();
      bus.in_valid = 1'b0;
      e = head_exp();
      n_checks++;
      if ({bus.out_valid, bus.out_addr, bus.out_misalign, obs()} !==
          {1'b1, tb_addr[i], tb_mis[i], e}) begin
        n_errors++;
        $display("FAIL wrap_mis[%0d]: got v=%0b addr=%h mis=%0b required v=1 addr=%h mis=%0b",
                 i, bus.out_valid, bus.out_addr, bus.out_misalign, tb_addr[i], tb_mis[i]);
      end
      advance();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    ent_t e;
    int   tag;
    int   acc;
    logic took;
    bus.out_ready = 1'b0;
    tag = 1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive_req(32'h2000, 32'(tag) << 2, 5'b00010, 3'(tag), 32'hB0 + 32'(tag));
      e = head_exp();
      n_checks++;
      if ({bus.out_valid, bus.in_ready, obs()} !== {sb.size() != 0, sb.size() < 4, e}) begin
        n_errors++;
        $display("FAIL bp_fill[%0d]: got v=%0b r=%0b %h required v=%0b r=%0b %h", c,
                 bus.out_valid, bus.in_ready, obs(), sb.size() != 0, sb.size() < 4, e);
      end
      took = bus.in_ready;
      advance();
      if (took) begin
        acc++;
        tag++;
      end
    end
    n_checks++;
    if (acc !== 4) begin
      n_errors++;
      $display("FAIL bp_accepts: got %0d required 4", acc);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      e = head_exp();
      n_checks++;
      if ({bus.out_valid, bus.out_rob, obs()} !== {1'b1, 3'(i), e}) begin
        n_errors++;
        $display("FAIL bp_order[%0d]: got v=%0b rob=%0d required v=1 rob=%0d",
                 i, bus.out_valid, bus.out_rob, i);
      end
      if (i <= 2) begin
        n_checks++;
        if (bus.in_ready !== (i == 2)) begin
          n_errors++;
          $display("FAIL bp_ready[%0d]: got %0b required %0b", i, bus.in_ready, i == 2);
        end
      end
      advance();
      if (i == 2) bus.in_valid = 1'b0;
    end
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL bp_drained: got v=%0b r=%0b required v=0 r=1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    ent_t e;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_req(32'h3000, 32'(i) << 1, 5'b00001, 3'(i), 32'hC0 + 32'(i));
      advance();
    end
    for (int k = 0; k < 10; k++) begin
      bus.out_ready = 1'b1;
      drive_req(32'h3000 + 32'(k), 32'h3, 5'b00001, 3'((k + 2) % 8), 32'hD0 + 32'(k));
      e = head_exp();
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_rob, obs()} !== {1'b1, 1'b1, 3'(k % 8), e}) begin
        n_errors++;
        $display("FAIL b2b[%0d]: got v=%0b r=%0b rob=%0d %h required v=1 r=1 rob=%0d %h", k,
                 bus.out_valid, bus.in_ready, bus.out_rob, obs(), k % 8, e);
      end
      advance();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = head_exp();
      n_checks++;
      if ({bus.out_valid, obs()} !== {1'b1, e}) begin
        n_errors++;
        $display("FAIL b2b_tail[%0d]: got v=%0b %h required v=1 %h", k, bus.out_valid, obs(), e);
      end
      advance();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_empty: got v=%0b required v=0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    ent_t e;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_req(32'h4000, 32'(i) << 2, 5'b00010, 3'(i), 32'hE0 + 32'(i));
      advance();
    end
    // Offer a request and a pop in the flush cycle; flush must win both.
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive_req(32'h5000, 32'h0, 5'b01010, 3'd7, 32'hDEAD_BEEF);
    e = head_exp();
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_rob, obs()} !== {1'b1, 1'b1, 3'd1, e}) begin
      n_errors++;
      $display("FAIL flush_pre: got v=%0b r=%0b %h required v=1 r=1 %h",
               bus.out_valid, bus.in_ready, obs(), e);
    end
    advance();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({bus.out_valid, bus.in_ready, obs()} !== {1'b0, 1'b1, Idle}) begin
        n_errors++;
        $display("FAIL flush_empty[%0d]: got v=%0b r=%0b %h required v=0 r=1 %h", k,
                 bus.out_valid, bus.in_ready, obs(), Idle);
      end
      advance();
    end
    bus.out_ready = 1'b0;
    drive_req(32'h40, 32'h0, 5'b00010, 3'd4, 32'h44);
    advance();
    bus.in_valid = 1'b0;
    e = head_exp();
    n_checks++;
    if ({bus.out_valid, bus.out_rob, obs()} !== {1'b1, 3'd4, e}) begin
      n_errors++;
      $display("FAIL flush_after: got v=%0b rob=%0d %h required v=1 rob=4 %h",
               bus.out_valid, bus.out_rob, obs(), e);
    end
    bus.out_ready = 1'b1;
    advance();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_drain: got v=%0b required v=0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_base   = '0;
    bus.in_offset = '0;
    bus.in_op     = '0;
    bus.in_rob    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap_misalign();
    test_backpressure();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
